// File: rtl/spm_portb_arbiter.sv
// -----------------------------------------------------------------------------
// spm_portb_arbiter
//
// Shares port B of the dual-port scratch-pad memory between two masters:
//   M0 (bus interface) and M1 (DMA/loader).
// The SPM has a 1-cycle registered read. The arbiter is a pure sequencer: it
// steers one master's request onto the SPM pins per cycle and pulses that
// master's ack in the following cycle, passing the SPM read data straight
// through. It does no data buffering.
//
// Arbitration is round-robin between the eligible masters. A master whose ack
// is in the current cycle is not eligible, so it is never granted twice in a
// row. This means:
//   - a single master gets at most one access every 2 cycles;
//   - two contending masters alternate M0, M1, M0, ... at one access per cycle.
//
// Parameters
//   ADDR_W  SPM word-address width
//   DATA_W  SPM word width
//
// Ports
//   clk          clock, also the SPM port B clock
//   reset        asynchronous, active-low reset
//   m0_req       M0 request, held until m0_ack
//   m0_we        M0 write(1)/read(0)
//   m0_addr      M0 word address
//   m0_wr_data   M0 write data
//   m0_ack       1-cycle pulse, M0 access complete
//   m0_rd_data   M0 read data, zero unless m0_ack
//   m1_*         same set of signals for M1
//   spm_en       SPM port B enable
//   spm_we       SPM port B write enable
//   spm_addr     SPM port B address
//   spm_wr_data  SPM port B write data
//   spm_rd_data  SPM port B read data (registered inside the SPM)
// -----------------------------------------------------------------------------
module spm_portb_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wr_data,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rd_data,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wr_data,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rd_data,

    output logic              spm_en,
    output logic              spm_we,
    output logic [ADDR_W-1:0] spm_addr,
    output logic [DATA_W-1:0] spm_wr_data,
    input  logic [DATA_W-1:0] spm_rd_data
);

    // Access issued last cycle whose ack is due now.
    logic inflight_vld_q, inflight_vld_d;
    logic inflight_id_q,  inflight_id_d;
    // Master granted most recently; the other one wins the next contest.
    logic last_grant_q,   last_grant_d;

    logic elig0, elig1;
    logic grant_vld;
    logic grant_id;

    // -------------------------------------------------------------------------
    // Grant decision for the current cycle
    // -------------------------------------------------------------------------
    always_comb begin
        elig0 = m0_req && !(inflight_vld_q && (inflight_id_q == 1'b0));
        elig1 = m1_req && !(inflight_vld_q && (inflight_id_q == 1'b1));

        // Outputs are held at zero while reset is asserted, even if requests
        // are present.
        grant_vld = reset && (elig0 || elig1);

        if (elig0 && elig1) begin
            grant_id = ~last_grant_q;
        end else begin
            grant_id = elig1;
        end
    end

    assign spm_en      = grant_vld;
    assign spm_we      = grant_vld && (grant_id ? m1_we : m0_we);
    assign spm_addr    = grant_vld ? (grant_id ? m1_addr    : m0_addr)    : '0;
    assign spm_wr_data = grant_vld ? (grant_id ? m1_wr_data : m0_wr_data) : '0;

    // -------------------------------------------------------------------------
    // Completion: ack and read-data pass-through for last cycle's grant.
    // -------------------------------------------------------------------------
    assign m0_ack     = reset && inflight_vld_q && (inflight_id_q == 1'b0);
    assign m1_ack     = reset && inflight_vld_q && (inflight_id_q == 1'b1);
    assign m0_rd_data = m0_ack ? spm_rd_data : '0;
    assign m1_rd_data = m1_ack ? spm_rd_data : '0;

    // -------------------------------------------------------------------------
    // State update
    // -------------------------------------------------------------------------
    always_comb begin
        inflight_vld_d = grant_vld;
        inflight_id_d  = grant_vld ? grant_id : inflight_id_q;
        last_grant_d   = grant_vld ? grant_id : last_grant_q;
    end

    // last_grant resets to M1, so M0 wins the first contested cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight_vld_q <= 1'b0;
            inflight_id_q  <= 1'b0;
            last_grant_q   <= 1'b1;
        end else begin
            inflight_vld_q <= inflight_vld_d;
            inflight_id_q  <= inflight_id_d;
            last_grant_q   <= last_grant_d;
        end
    end

endmodule
